multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the write enables, mux selects and memory requests for the PC, instruction register, register file, ALU and data memory. It takes the opcode, fn3 and rd fields from the instruction decoder, which sits behind the instruction register. It also keeps a retired-instruction counter and enters a sticky trap state on an unsupported opcode.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  decoder opcode field, valid from DECODE onward
- fn3  in  3  decoder fn3 field
- rd  in  5  decoder destination register
- br_taken  in  1  branch comparator result, valid in EXEC
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_ready  in  1  data memory access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0=pc+4, 1=pc+imm, 2=alu result with bit0 cleared
- alu_a_sel  out  2  0=rs1, 1=pc, 2=zero
- alu_b_sel  out  1  0=rs2, 1=imm
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_size  out  2  fn3[1:0] passthrough during MEM
- reg_we  out  1  register file write
- wb_sel  out  2  0=alu, 1=mem data, 2=pc+4
- trap  out  1  illegal opcode seen, core halted
- state  out  3  current state encoding
- instret  out  CNT_W  count of retired instructions

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH
  - imem_req=1 every cycle spent in FETCH.
  - When imem_ready=1: ir_we=1 and the next state is DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 1101111 (JAL), 1100111 (JALR), 0110111 (LUI), 0010111 (AUIPC).
  - Any supported opcode goes to EXEC.
  - Any other opcode goes to TRAP.
- EXEC operand selects:
  - R: a=0, b=0.
  - I-ALU, LOAD, STORE, JALR: a=0, b=1.
  - LUI: a=2, b=1.
  - AUIPC: a=1, b=1.
  - BRANCH: a=0, b=0; the comparator resolves br_taken.
- EXEC next state:
  - BRANCH: pc_we=1 with pc_sel=1 if br_taken, else pc_sel=0. Next state FETCH.
  - LOAD, STORE: next state MEM.
  - All other supported opcodes: next state WB.
- MEM
  - dmem_req=1 and dmem_size=fn3[1:0] while in MEM; dmem_we=1 for STORE.
  - Hold in MEM until dmem_ready=1.
  - STORE completes with pc_we=1, pc_sel=0 and goes to FETCH.
  - LOAD goes to WB.
- WB
  - reg_we=1 unless rd==0.
  - wb_sel: 1 for LOAD, 2 for JAL and JALR, 0 otherwise.
  - pc_we=1 with pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - Next state FETCH.
- TRAP
  - Absorbing state; only reset leaves it.
  - trap=1; every enable and request output is 0.
- instret increments by 1 on each cycle where pc_we=1. It wraps modulo 2^CNT_W.
- Outputs are combinational from state, opcode, br_taken and the ready inputs. Outputs not named for a state are 0.

## Timing
- Reset, asynchronous: state=FETCH, instret=0, trap=0, and all request and enable outputs are 0 while rst_n=0.
- The first imem_req is asserted in the first cycle after rst_n deasserts.
- Latency with zero-wait memory (imem_ready and dmem_ready high in the same cycle as the request):
  - BRANCH: 3 cycles.
  - R, I-ALU, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle on imem_ready or dmem_ready adds one cycle. The request stays high and every other output is held.
- A ready input outside its own state (imem_ready outside FETCH, dmem_ready outside MEM) is ignored.
- br_taken is sampled only in EXEC of a BRANCH.
- Reset mid-instruction returns to FETCH immediately:
  - the pending imem_req/dmem_req drops;
  - no pc_we, reg_we or dmem_we is issued;
  - instret clears.

## Test plan
- R-type: instr 0x00848933 (add, rd=18), zero-wait memory.
  - States 0,1,2,4,0.
  - reg_we=1 with wb_sel=0 in WB; pc_we=1 with pc_sel=0.
  - instret 0→1.
- Load/store:
  - 0x0002a303 (lw): MEM holds for 2 cycles with dmem_ready=0; dmem_req=1, dmem_we=0, dmem_size=2; then WB with wb_sel=1. Total 7 cycles.
  - 0x0082a223 (sw): dmem_we=1 in MEM; returns to FETCH with reg_we never asserted.
- Branch and jumps:
  - 0x014c6463 (bltu) with br_taken=1: pc_sel=1 in EXEC, 3 cycles. With br_taken=0: pc_sel=0.
  - 0x0000006f (jal, rd=0): WB with pc_sel=1, wb_sel=2 and reg_we=0.
  - 0x7ff080e7 (jalr, rd=1): pc_sel=2 and reg_we=1.
- Upper immediates:
  - 0x872370b7 (lui): alu_a_sel=2, alu_b_sel=1 in EXEC.
  - 0x10000917 (auipc): alu_a_sel=1, alu_b_sel=1 in EXEC.
- Illegal and reset:
  - Instr 0x0000007f: TRAP after DECODE; trap=1 for at least 10 cycles with no requests.
  - rst_n pulse: state=0, trap=0, instret=0.
  - rst_n asserted during MEM with dmem_req=1: dmem_req drops the same cycle; no dmem_we.
- Counter wrap: CNT_W=4, retire 17 instructions → instret=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with
// datapath enables, mux selects, memory requests, retired counter and sticky trap.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       fn3,
    input  logic [4:0]       rd,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [1:0]       dmem_size,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_legal;
    logic             w_unused;

    assign w_unused = fn3[2];
    assign state    = r_state;
    assign instret  = r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Every retired instruction updates the PC exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (pc_we) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Outputs are forced low while reset is held, so a pending request drops at once.
    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_size = 2'd0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        trap      = 1'b0;
        w_legal   = opcode inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
                                   OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we  = 1'b1;
                        w_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    w_next = w_legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    w_next = S_WB;
                    case (opcode)
                        OP_IALU, OP_JALR: alu_b_sel = 1'b1;
                        OP_LOAD, OP_STORE: begin
                            alu_b_sel = 1'b1;
                            w_next    = S_MEM;
                        end
                        OP_LUI: begin
                            alu_a_sel = 2'd2;
                            alu_b_sel = 1'b1;
                        end
                        OP_AUIPC: begin
                            alu_a_sel = 2'd1;
                            alu_b_sel = 1'b1;
                        end
                        OP_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_sel = br_taken ? 2'd1 : 2'd0;
                            w_next = S_FETCH;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    dmem_size = fn3[1:0];
                    dmem_we   = (opcode == OP_STORE);
                    if (dmem_ready) begin
                        if (opcode == OP_STORE) begin
                            pc_we  = 1'b1;
                            w_next = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we = (rd != 5'd0);
                    pc_we  = 1'b1;
                    w_next = S_FETCH;
                    if (opcode == OP_LOAD) begin
                        wb_sel = 2'd1;
                    end else if (opcode == OP_JAL) begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd1;
                    end else if (opcode == OP_JALR) begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd2;
                    end
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle comparison against an
// instruction-level reference trace, directed scenarios plus randomized programs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  fn3;
    logic [4:0]  rd;
    logic        br_taken, imem_ready, dmem_ready;
    logic        imem_req, ir_we, pc_we, alu_b_sel, dmem_req, dmem_we, reg_we, trap;
    logic [1:0]  pc_sel, alu_a_sel, dmem_size, wb_sel;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        imem_req4, ir_we4, pc_we4, alu_b_sel4, dmem_req4, dmem_we4, reg_we4, trap4;
    logic [1:0]  pc_sel4, alu_a_sel4, dmem_size4, wb_sel4;
    logic [2:0]  state4;
    logic [3:0]  instret4;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .fn3(fn3), .rd(rd), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size), .reg_we(reg_we),
        .wb_sel(wb_sel), .trap(trap), .state(state), .instret(instret)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .fn3(fn3), .rd(rd), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req4), .ir_we(ir_we4),
        .pc_we(pc_we4), .pc_sel(pc_sel4), .alu_a_sel(alu_a_sel4), .alu_b_sel(alu_b_sel4),
        .dmem_req(dmem_req4), .dmem_we(dmem_we4), .dmem_size(dmem_size4), .reg_we(reg_we4),
        .wb_sel(wb_sel4), .trap(trap4), .state(state4), .instret(instret4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [1:0] a_sel;
        logic       b_sel;
        logic       dmem_req;
        logic       dmem_we;
        logic [1:0] dmem_size;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       trap;
    } outv_t;

    typedef struct packed {
        outv_t e;
        logic  irdy;
        logic  drdy;
        logic  br;
    } step_t;

    typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_t;

    step_t       q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_instret = '0;

    function automatic kind_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic outv_t sample();
        return outv_t'({state, imem_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                        dmem_req, dmem_we, dmem_size, reg_we, wb_sel, trap});
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        logic [31:0] r;
        r      = $urandom;
        r[6:0] = ops[$urandom_range(0, 8)];
        return r;
    endfunction

    // Expected cycle-by-cycle trace of one instruction, derived from its class.
    task automatic build(input logic [31:0] instr, input logic br, input int iw, input int dw,
                         input int ntrap);
        kind_t k;
        step_t s;
        k = classify(instr[6:0]);
        q.delete();
        for (int i = 0; i <= iw; i++) begin
            s = '0;
            s.e.imem_req = 1'b1;
            s.e.ir_we    = (i == iw);
            s.irdy       = (i == iw);
            s.drdy       = 1'($urandom);
            s.br         = 1'($urandom);
            q.push_back(s);
        end
        s = '0; s.e.st = 3'd1;
        s.irdy = 1'($urandom); s.drdy = 1'($urandom); s.br = 1'($urandom);
        q.push_back(s);
        if (k == K_BAD) begin
            for (int i = 0; i < ntrap; i++) begin
                s = '0; s.e.st = 3'd5; s.e.trap = 1'b1;
                s.irdy = 1'($urandom); s.drdy = 1'($urandom); s.br = 1'($urandom);
                q.push_back(s);
            end
            return;
        end
        s = '0; s.e.st = 3'd2;
        s.irdy = 1'($urandom); s.drdy = 1'($urandom); s.br = 1'($urandom);
        case (k)
            K_I, K_LD, K_ST, K_JALR: s.e.b_sel = 1'b1;
            K_LUI:   begin s.e.a_sel = 2'd2; s.e.b_sel = 1'b1; end
            K_AUIPC: begin s.e.a_sel = 2'd1; s.e.b_sel = 1'b1; end
            K_BR:    begin s.br = br; s.e.pc_we = 1'b1; s.e.pc_sel = br ? 2'd1 : 2'd0; end
            default: ;
        endcase
        q.push_back(s);
        if (k == K_LD || k == K_ST) begin
            for (int j = 0; j <= dw; j++) begin
                s = '0; s.e.st = 3'd3;
                s.e.dmem_req  = 1'b1;
                s.e.dmem_we   = (k == K_ST);
                s.e.dmem_size = instr[13:12];
                s.e.pc_we     = (k == K_ST) && (j == dw);
                s.drdy = (j == dw); s.irdy = 1'($urandom); s.br = 1'($urandom);
                q.push_back(s);
            end
        end
        if (k != K_BR && k != K_ST) begin
            s = '0; s.e.st = 3'd4;
            s.e.reg_we = (instr[11:7] != 5'd0);
            s.e.pc_we  = 1'b1;
            s.e.wb_sel = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
            s.e.pc_sel = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
            s.irdy = 1'($urandom); s.drdy = 1'($urandom); s.br = 1'($urandom);
            q.push_back(s);
        end
    endtask

    // Drives one instruction, compares every cycle, reports cycles until back in FETCH.
    task automatic run(input string tag, input logic [31:0] instr, input logic br, input int iw,
                       input int dw, input int ntrap, output int obs);
        outv_t o;
        build(instr, br, iw, dw, ntrap);
        obs = 0;
        foreach (q[i]) begin
            @(negedge clk);
            imem_ready = q[i].irdy;
            dmem_ready = q[i].drdy;
            br_taken   = q[i].br;
            if (q[i].e.st == 3'd0) begin
                opcode = 7'($urandom); fn3 = 3'($urandom); rd = 5'($urandom);
            end else begin
                opcode = instr[6:0]; fn3 = instr[14:12]; rd = instr[11:7];
            end
            #1;
            o = sample();
            n_checks++;
            if (o !== q[i].e) begin
                n_fail++;
                $display("FAIL %s cycle %0d outputs: got %h expected %h", tag, i, o, q[i].e);
            end
            n_checks++;
            if (instret !== m_instret || instret4 !== m_instret[3:0]) begin
                n_fail++;
                $display("FAIL %s cycle %0d instret: got %0d/%0d expected %0d/%0d",
                         tag, i, instret, instret4, m_instret, m_instret[3:0]);
            end
            if (q[i].e.pc_we) m_instret++;
            obs++;
        end
        if (ntrap == 0) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                imem_ready = 1'b0;
                #1;
                if (state == 3'd0) break;
                obs++;
            end
        end
    endtask

    task automatic test_reset();
        outv_t zero = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        n_checks++;
        if (sample() !== zero || instret !== 32'd0 || instret4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_assert: got %h/%0d/%0d expected 0", sample(), instret, instret4);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sample() !== zero) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected 0", sample());
        end
        @(negedge clk);
        imem_ready = 1'b0;
        rst_n      = 1'b1;
        m_instret  = '0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || state !== 3'd0 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got req=%b state=%0d trap=%b expected 1/0/0",
                     imem_req, state, trap);
        end
    endtask

    task automatic test_rtype();
        int obs;
        run("add", 32'h00848933, 1'b0, 0, 0, 0, obs);
        n_checks++;
        if (obs !== 4) begin n_fail++; $display("FAIL add_latency: got %0d expected 4", obs); end
    endtask

    task automatic test_load_store();
        int obs;
        run("lw", 32'h0002a303, 1'b0, 0, 2, 0, obs);
        n_checks++;
        if (obs !== 7) begin n_fail++; $display("FAIL lw_latency: got %0d expected 7", obs); end
        run("sw", 32'h0082a223, 1'b0, 0, 0, 0, obs);
        n_checks++;
        if (obs !== 4) begin n_fail++; $display("FAIL sw_latency: got %0d expected 4", obs); end
        run("sw_wait", 32'h0082a223, 1'b0, 2, 1, 0, obs);
        n_checks++;
        if (obs !== 7) begin n_fail++; $display("FAIL sw_wait_latency: got %0d expected 7", obs); end
    endtask

    task automatic test_branch();
        int obs;
        run("bltu_t", 32'h014c6463, 1'b1, 0, 0, 0, obs);
        n_checks++;
        if (obs !== 3) begin n_fail++; $display("FAIL bltu_t_latency: got %0d expected 3", obs); end
        run("bltu_nt", 32'h014c6463, 1'b0, 1, 0, 0, obs);
        n_checks++;
        if (obs !== 4) begin n_fail++; $display("FAIL bltu_nt_latency: got %0d expected 4", obs); end
    endtask

    task automatic test_jumps();
        int obs;
        run("jal", 32'h0000006f, 1'b0, 0, 0, 0, obs);
        n_checks++;
        if (obs !== 4) begin n_fail++; $display("FAIL jal_latency: got %0d expected 4", obs); end
        run("jalr", 32'h7ff080e7, 1'b0, 0, 0, 0, obs);
        n_checks++;
        if (obs !== 4) begin n_fail++; $display("FAIL jalr_latency: got %0d expected 4", obs); end
    endtask

    task automatic test_upper();
        int obs;
        run("lui", 32'h872370b7, 1'b0, 0, 0, 0, obs);
        n_checks++;
        if (obs !== 4) begin n_fail++; $display("FAIL lui_latency: got %0d expected 4", obs); end
        run("auipc", 32'h10000917, 1'b0, 0, 0, 0, obs);
        n_checks++;
        if (obs !== 4) begin n_fail++; $display("FAIL auipc_latency: got %0d expected 4", obs); end
    endtask

    task automatic test_random();
        int obs;
        for (int i = 0; i < 40; i++) begin
            run("random", rand_legal(), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), 0, obs);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [31:0] sw = 32'h0082a223;
        @(negedge clk);
        imem_ready = 1'b1; dmem_ready = 1'b0;
        opcode = sw[6:0]; fn3 = sw[14:12]; rd = sw[11:7];
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || instret !== m_instret) begin
            n_fail++;
            $display("FAIL mid_mem_pre: got state=%0d req=%b we=%b instret=%0d expected 3/1/1/%0d",
                     state, dmem_req, dmem_we, instret, m_instret);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0 ||
            state !== 3'd0 || instret !== 32'd0 || instret4 !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_mem_reset: got req=%b we=%b pc_we=%b state=%0d instret=%0d expected all 0",
                     dmem_req, dmem_we, pc_we, state, instret);
        end
        @(negedge clk);
        dmem_ready = 1'b1;
        #1;
        n_checks++;
        if (dmem_we !== 1'b0 || pc_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_mem_hold: got we=%b pc_we=%b expected 0/0", dmem_we, pc_we);
        end
        @(negedge clk);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        rst_n      = 1'b1;
        m_instret  = '0;
    endtask

    task automatic test_trap();
        int obs;
        run("trap", 32'h0000007f, 1'b0, 0, 0, 12, obs);
        n_checks++;
        if (trap !== 1'b1 || imem_req !== 1'b0 || state !== 3'd5) begin
            n_fail++;
            $display("FAIL trap_sticky: got trap=%b req=%b state=%0d expected 1/0/5",
                     trap, imem_req, state);
        end
    endtask

    task automatic test_wrap();
        int obs;
        test_reset();
        for (int i = 0; i < 17; i++) begin
            run("wrap", rand_legal(), 1'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                0, obs);
        end
        n_checks++;
        if (instret !== 32'd17 || instret4 !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap: got %0d/%0d expected 17/1", instret, instret4);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; fn3 = '0; rd = '0;
        br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_jumps();
        test_upper();
        test_random();
        test_reset_mid_mem();
        test_trap();
        test_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
